// File: rtl/btb_predictor_pkg.sv
// Shared types and constants for the branch target buffer.
package btb_predictor_pkg;

    localparam int BTB_WIDTH = 32;
    localparam int BTB_AGE_W = 6;

    localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;
    localparam logic [1:0] CTR_MAX        = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [BTB_WIDTH-1:0] tag;
        logic [BTB_WIDTH-1:0] target;
        logic [1:0]           ctr;
        logic [BTB_AGE_W-1:0] age;
    } btb_entry_t;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch-side lookup and EX-side update bundle for the BTB; outputs are
// combinational from PC, so there is no flow control on either side.
interface btb_predictor_if
    import btb_predictor_pkg::*;
#(
    parameter int WIDTH = BTB_WIDTH
);
    logic             clr;
    logic [WIDTH-1:0] PC;
    logic             predictJump;
    logic [WIDTH-1:0] jumpAddr;
    logic             updEn;
    logic [WIDTH-1:0] EXPC;
    logic             EXBranch;
    logic             EXBranchTaken;
    logic [WIDTH-1:0] EXBranchAddr;
    logic [15:0]      hitCount;

    modport master (
        output clr, PC, updEn, EXPC, EXBranch, EXBranchTaken, EXBranchAddr,
        input  predictJump, jumpAddr, hitCount
    );

    modport slave (
        input  clr, PC, updEn, EXPC, EXBranch, EXBranchTaken, EXBranchAddr,
        output predictJump, jumpAddr, hitCount
    );
endinterface

// File: rtl/btb_predictor_lru.sv
// True-LRU age tracker: touch takes effect on the next edge, victim/ages are
// combinational from state; no backpressure, a touch is always accepted.
module btb_lru #(
    parameter int SIZE  = 8,
    parameter int IDX_W = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             touch_i,
    input  logic [IDX_W-1:0] touch_idx_i,
    output logic [IDX_W-1:0] victim_o,
    output logic [IDX_W-1:0] age_o [SIZE]
);

    logic [IDX_W-1:0] age_q [SIZE];
    logic [IDX_W-1:0] age_d [SIZE];
    logic [IDX_W-1:0] old_age;

    assign old_age = age_q[touch_idx_i];

    // Entries younger than the touched one each age by one; others keep order.
    always_comb begin
        for (int j = 0; j < SIZE; j++) begin
            age_d[j] = age_q[j];
            if (touch_i) begin
                if (IDX_W'(j) == touch_idx_i) begin
                    age_d[j] = '0;
                end else if (age_q[j] < old_age) begin
                    age_d[j] = age_q[j] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        victim_o = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (age_q[i] == IDX_W'(SIZE - 1)) begin
                victim_o = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                age_q[i] <= IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign age_o = age_q;

endmodule

// File: rtl/btb_predictor.sv
// Fully-associative BTB with 2-bit counters: lookup is 0-cycle combinational,
// updates land on the next edge; updEn=0 stalls all state, nothing is ever refused.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int WIDTH = BTB_WIDTH,
    parameter int SIZE  = 8
) (
    input  logic            clk,
    input  logic            rst,
    btb_predictor_if.slave  bus
);

    localparam int IDX_W = $clog2(SIZE);

    logic [SIZE-1:0]  valid_q, valid_d;
    logic [WIDTH-1:0] tag_q    [SIZE];
    logic [WIDTH-1:0] tag_d    [SIZE];
    logic [WIDTH-1:0] target_q [SIZE];
    logic [WIDTH-1:0] target_d [SIZE];
    logic [1:0]       ctr_q    [SIZE];
    logic [1:0]       ctr_d    [SIZE];
    logic [15:0]      hit_cnt_q, hit_cnt_d;

    logic [IDX_W-1:0] age [SIZE];
    logic [IDX_W-1:0] lru_victim;
    btb_entry_t       ent [SIZE];

    logic             look_hit, upd_hit, free_any, upd_req, touch;
    logic [IDX_W-1:0] look_idx, upd_idx, free_idx, alloc_idx, touch_idx;

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            ent[i] = '{valid:  valid_q[i],
                       tag:    tag_q[i],
                       target: target_q[i],
                       ctr:    ctr_q[i],
                       age:    BTB_AGE_W'(age[i])};
        end
    end

    // Tags are full PCs, so at most one entry matches on either port.
    always_comb begin
        look_hit = 1'b0;
        look_idx = '0;
        upd_hit  = 1'b0;
        upd_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (ent[i].valid && ent[i].tag == bus.PC) begin
                look_hit = 1'b1;
                look_idx = IDX_W'(i);
            end
            if (ent[i].valid && ent[i].tag == bus.EXPC) begin
                upd_hit = 1'b1;
                upd_idx = IDX_W'(i);
            end
        end
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (!ent[i].valid) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign bus.predictJump = look_hit && ent[look_idx].ctr[1];
    assign bus.jumpAddr    = bus.predictJump ? ent[look_idx].target : '0;
    assign bus.hitCount    = hit_cnt_q;

    assign upd_req   = bus.updEn && bus.EXBranch && !bus.clr;
    assign alloc_idx = free_any ? free_idx : lru_victim;
    assign touch     = upd_req && (upd_hit || bus.EXBranchTaken);
    assign touch_idx = upd_hit ? upd_idx : alloc_idx;

    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        hit_cnt_d = hit_cnt_q;
        if (bus.clr) begin
            valid_d = '0;
        end else if (upd_req) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = ctr_step(ctr_q[upd_idx], bus.EXBranchTaken);
                if (bus.EXBranchTaken) begin
                    target_d[upd_idx] = bus.EXBranchAddr;
                end
                if (hit_cnt_q != 16'hFFFF) begin
                    hit_cnt_d = hit_cnt_q + 16'd1;
                end
            end else if (bus.EXBranchTaken) begin
                valid_d[alloc_idx]  = 1'b1;
                tag_d[alloc_idx]    = bus.EXPC;
                target_d[alloc_idx] = bus.EXBranchAddr;
                ctr_d[alloc_idx]    = CTR_WEAK_TAKEN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            hit_cnt_q <= '0;
            for (int i = 0; i < SIZE; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            hit_cnt_q <= hit_cnt_d;
            for (int i = 0; i < SIZE; i++) begin
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

    btb_lru #(
        .SIZE  (SIZE),
        .IDX_W (IDX_W)
    ) u_lru (
        .clk         (clk),
        .rst         (rst),
        .touch_i     (touch),
        .touch_idx_i (touch_idx),
        .victim_o    (lru_victim),
        .age_o       (age)
    );

    // Eviction of a full table must always land on the oldest entry.
    a_victim_oldest: assert property (@(posedge clk) disable iff (rst)
        (touch && !upd_hit && !free_any) |-> ent[alloc_idx].age == BTB_AGE_W'(SIZE - 1));

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench: driver pushes model predictions, monitor compares DUT lookups.
module tb_btb_predictor;
    import btb_predictor_pkg::*;

    localparam int SIZE = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btb_predictor_if #(.WIDTH(32)) bus();

    btb_predictor #(.WIDTH(32), .SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        pj;
        logic [31:0] ja;
        logic [15:0] hc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: slot contents plus a recency list (front = most recent).
    logic        m_valid [SIZE];
    logic [31:0] m_tag   [SIZE];
    logic [31:0] m_tgt   [SIZE];
    int          m_ctr   [SIZE];
    int          order[$];
    int          m_hits;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        order = {};
        for (int i = 0; i < SIZE; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 0;
            order.push_back(i);
        end
        m_hits = 0;
    endfunction

    function automatic int m_find(input logic [31:0] pc);
        for (int s = 0; s < SIZE; s++) begin
            if (m_valid[s] && m_tag[s] == pc) return s;
        end
        return -1;
    endfunction

    function automatic void m_touch(input int s);
        int pos = 0;
        for (int k = 0; k < order.size(); k++) begin
            if (order[k] == s) pos = k;
        end
        order.delete(pos);
        order.push_front(s);
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output logic pj, output logic [31:0] ja);
        int s = m_find(pc);
        pj = (s >= 0) && (m_ctr[s] >= 2);
        ja = pj ? m_tgt[s] : 32'h0;
    endfunction

    function automatic void m_update(input logic en, input logic br, input logic tk,
                                     input logic [31:0] xpc, input logic [31:0] xaddr,
                                     input logic c);
        int s;
        if (c) begin
            for (int i = 0; i < SIZE; i++) m_valid[i] = 1'b0;
            return;
        end
        if (!(en && br)) return;
        s = m_find(xpc);
        if (s >= 0) begin
            if (m_hits < 16'hFFFF) m_hits++;
            if (tk) begin
                m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
                m_tgt[s] = xaddr;
            end else begin
                m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
            end
            m_touch(s);
        end else if (tk) begin
            s = -1;
            for (int i = SIZE - 1; i >= 0; i--) begin
                if (!m_valid[i]) s = i;
            end
            if (s < 0) s = order[SIZE-1];
            m_valid[s] = 1'b1;
            m_tag[s]   = xpc;
            m_tgt[s]   = xaddr;
            m_ctr[s]   = 2;
            m_touch(s);
        end
    endfunction

    task automatic cyc(input logic [31:0] pc, input logic en, input logic br, input logic tk,
                       input logic [31:0] xpc, input logic [31:0] xaddr, input logic c);
        exp_t e;
        @(negedge clk);
        bus.PC            = pc;
        bus.updEn         = en;
        bus.EXBranch      = br;
        bus.EXBranchTaken = tk;
        bus.EXPC          = xpc;
        bus.EXBranchAddr  = xaddr;
        bus.clr           = c;
        m_lookup(pc, e.pj, e.ja);
        e.hc = 16'(m_hits);
        exp_q.push_back(e);
        m_update(en, br, tk, xpc, xaddr, c);
    endtask

    task automatic look(input logic [31:0] pc);
        cyc(pc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] xpc, input logic tk,
                       input logic [31:0] xaddr);
        cyc(pc, 1'b1, 1'b1, tk, xpc, xaddr, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("predictJump", 32'(bus.predictJump), 32'(e.pj));
                check("jumpAddr", bus.jumpAddr, e.ja);
                check("hitCount", 32'(bus.hitCount), 32'(e.hc));
            end
        end
    end

    initial begin : driver
        logic        pj;
        logic [31:0] ja;
        bus.PC = 32'h10; bus.updEn = 1'b0; bus.EXBranch = 1'b0; bus.EXBranchTaken = 1'b0;
        bus.EXPC = '0; bus.EXBranchAddr = '0; bus.clr = 1'b0;
        model_reset();
        #1;
        check("reset_predictJump", 32'(bus.predictJump), 32'h0);
        check("reset_jumpAddr", bus.jumpAddr, 32'h0);
        check("reset_hitCount", 32'(bus.hitCount), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Counter training on 0x10.
        look(32'h10);
        upd(32'h10, 32'h10, 1'b1, 32'h40);
        upd(32'h10, 32'h10, 1'b1, 32'h40);
        upd(32'h10, 32'h10, 1'b0, 32'h0);
        upd(32'h10, 32'h10, 1'b0, 32'h0);
        look(32'h10);

        // Fill the table, refresh 0x00, then force an eviction of 0x04.
        cyc(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < SIZE; i++) upd(32'h0, 32'(i * 4), 1'b1, 32'h1000 + 32'(i));
        upd(32'h0, 32'h0, 1'b1, 32'h2000);
        upd(32'h4, 32'h100, 1'b1, 32'h3000);
        look(32'h4);
        look(32'h0);
        look(32'h100);

        // Retarget a hit; same-cycle lookup sees the old target.
        upd(32'h20, 32'h20, 1'b1, 32'h60);
        upd(32'h20, 32'h20, 1'b1, 32'h80);
        look(32'h20);

        // Miss not-taken is ignored.
        upd(32'h30, 32'h30, 1'b0, 32'h0);
        look(32'h30);

        // Stall, then clr racing an update.
        for (int i = 0; i < 5; i++) cyc(32'h200, 1'b0, 1'b1, 1'b1, 32'h200, 32'h44, 1'b0);
        look(32'h200);
        cyc(32'h100, 1'b1, 1'b1, 1'b1, 32'h300, 32'h50, 1'b1);
        look(32'h300);
        look(32'h100);
        look(32'h20);

        // Asynchronous reset between edges.
        upd(32'h500, 32'h500, 1'b1, 32'h44);
        @(negedge clk);
        bus.PC = 32'h500; bus.updEn = 1'b0; bus.EXBranch = 1'b0; bus.clr = 1'b0;
        #1;
        m_lookup(32'h500, pj, ja);
        check("pre_rst_predictJump", 32'(bus.predictJump), 32'(pj));
        check("pre_rst_jumpAddr", bus.jumpAddr, ja);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_predictJump", 32'(bus.predictJump), 32'h0);
        check("async_rst_jumpAddr", bus.jumpAddr, 32'h0);
        check("async_rst_hitCount", 32'(bus.hitCount), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            cyc(32'($urandom_range(0, 15)) << 2,
                $urandom_range(0, 7) != 0,
                $urandom_range(0, 3) != 0,
                1'($urandom_range(0, 1)),
                32'($urandom_range(0, 15)) << 2,
                $urandom & 32'h0000_FFFC,
                $urandom_range(0, 63) == 0);
        end

        @(negedge clk);
        #5;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Fully-associative branch target buffer with 2-bit saturating direction counters and true-LRU replacement. It sits beside the IF stage of the pipelined CPU:
- Lookup side: the current fetch PC is looked up combinationally to produce the taken prediction and target used to form the next PC.
- Update side: resolved branch/jump outcomes from the EX stage are written back on the clock edge.

## Interface
Parameters:
- WIDTH, 32, address/data width
- SIZE, 8, number of entries (power of two, 2..64)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high; the only clock is clk
- clr  in  1  synchronous invalidate-all (no reset of LRU order)
- PC  in  WIDTH  fetch address to look up
- predictJump  out  1  prediction: taken
- jumpAddr  out  WIDTH  predicted target (0 when predictJump=0)
- updEn  in  1  update qualifier (driven with !halt)
- EXPC  in  WIDTH  PC of instruction in EX
- EXBranch  in  1  EX holds a conditional branch, JAL or JALR
- EXBranchTaken  in  1  resolved direction
- EXBranchAddr  in  WIDTH  resolved target
- hitCount  out  16  number of update-side hits, saturating

## Operation
- Entry state: valid (1b), tag (full WIDTH PC), target (WIDTH), ctr (2b), age (clog2(SIZE) b).
- Lookup (combinational):
  - Hit when valid and tag==PC. At most one entry can match.
  - predictJump = hit && ctr[1].
  - jumpAddr = target of the matching entry when predictJump=1, else 0.
- An update occurs when updEn && EXBranch at posedge clk.
- Update, hit on EXPC:
  - Taken: ctr = min(ctr+1, 3) and target ← EXBranchAddr.
  - Not taken: ctr = max(ctr-1, 0); target unchanged.
  - Entry is touched in the LRU.
- Update, miss, taken: allocate.
  - Victim is the lowest-index invalid entry; otherwise the entry with age = SIZE-1.
  - Written with tag=EXPC, target=EXBranchAddr, ctr=2'b10, valid=1.
  - The allocated entry is touched.
- Update, miss, not taken: no state change.
- LRU touch of entry k: age[k] ← 0; every entry j with age[j] < old age[k] gets age[j]+1. Ages always form a permutation of 0..SIZE-1.
- clr: all valid ← 0; ctr, target, tag and ages are untouched. clr has priority over a simultaneous update, so the update is dropped.
- hitCount increments on each update-side hit and saturates at 16'hFFFF. clr does not affect it.

## Timing
- Lookup latency is 0 cycles: predictJump/jumpAddr depend combinationally on PC and the current state.
- Update latency is 1 cycle: the new state is visible to lookups from the cycle after the edge.
- Same-cycle lookup and update of the same PC: the lookup returns the pre-update state.
- Reset (asynchronous, any time, including mid-update):
  - valid=0, ctr=0, target=0, tag=0, age[i]=i, hitCount=0.
  - Consequently predictJump=0 and jumpAddr=0 immediately.
- Reset deasserts synchronously with respect to clk, handled by the top-level reset synchronizer.
- updEn=0 freezes all state (halted pipeline repeatedly presents the same EX instruction).

## Structure
- A shared package holds:
  - the btb_entry_t struct (valid, tag, target, ctr, age)
  - CTR_WEAK_TAKEN = 2'b10 and CTR_MAX = 2'b11
- One sub-module, btb_lru: holds the age array and takes touch/index inputs. It outputs the victim index and owns the age reset values.
- The hit-match and priority encoders are inline in btb_predictor.

## Test plan
- Reset, then PC=0x10 → predictJump=0, jumpAddr=0, hitCount=0.
- Update EXPC=0x10 taken, target 0x40 → next cycle PC=0x10 gives predictJump=1, jumpAddr=0x40. A second taken update makes ctr=3. Two not-taken updates then give predictJump=0 (ctr=1), and hitCount=3.
- Fill 8 entries with PCs 0x00..0x1C taken; touch 0x00 again; allocate 0x100 → the entry for 0x04 is evicted. Lookup of 0x04 misses; lookups of 0x00 and 0x100 hit.
- Hit on 0x20 with a taken update to new target 0x80 → jumpAddr becomes 0x80 the next cycle. The same-cycle lookup still shows the old target.
- Miss, not taken (EXPC=0x30) → no entry is allocated, ages are unchanged, and hitCount is unchanged.
- updEn=0 for 5 cycles while holding a taken update → no state change. clr together with an update → all lookups miss and the update is lost. Asserting rst mid-cycle → outputs drop to 0 without a clock edge.
